// File: rtl/imm_gen_pkg.sv
// Shared types and constants for the registered immediate generator.
// Stored entries use the widest supported XLEN/tag and are narrowed at the output.
package imm_gen_pkg;

  localparam int unsigned INST_W    = 32;
  localparam int unsigned IMM_MAX_W = 64;
  localparam int unsigned TAG_MAX_W = 64;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_R    = 3'd1,
    FMT_I    = 3'd2,
    FMT_ISH  = 3'd3,
    FMT_S    = 3'd4,
    FMT_B    = 3'd5,
    FMT_U    = 3'd6,
    FMT_J    = 3'd7
  } imm_fmt_e;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;

  typedef struct packed {
    logic [IMM_MAX_W-1:0] imm;
    imm_fmt_e             fmt;
    logic                 illegal;
    logic [TAG_MAX_W-1:0] tag;
  } imm_entry_t;

  // funct3 values that select the shift-immediate form of OP-IMM / OP-IMM-32
  function automatic logic is_shift(input logic [2:0] funct3);
    return (funct3 == 3'b001) || (funct3 == 3'b101);
  endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle between the fetch/decode register and the immediate generator.
interface imm_gen_pipe_if
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
);

  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [INST_W-1:0]   in_inst;
  logic [TAG_W-1:0]    in_tag;
  logic                out_valid;
  logic                out_ready;
  logic [XLEN-1:0]     out_imm;
  imm_fmt_e            out_fmt;
  logic                out_illegal;
  logic [TAG_W-1:0]    out_tag;

  modport master (
    output flush, in_valid, in_inst, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );

  modport slave (
    input  flush, in_valid, in_inst, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );

endinterface

// File: rtl/imm_decode.sv
// Combinational RV32I/RV64I immediate decoder: instruction word -> imm, format, illegal.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [INST_W-1:0] inst,
  output logic [XLEN-1:0]   imm,
  output imm_fmt_e          fmt,
  output logic              illegal
);

  localparam bit IS64 = (XLEN == 64);

  logic [6:0]      opc;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] shamt5;
  logic [XLEN-1:0] shamt6;

  // Every format is built unconditionally; the opcode only picks one.
  always_comb begin
    opc    = inst[6:0];
    funct3 = inst[14:12];
    imm_i  = XLEN'($signed(inst[31:20]));
    imm_s  = XLEN'($signed({inst[31:25], inst[11:7]}));
    imm_b  = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
    imm_u  = XLEN'($signed({inst[31:12], 12'b0}));
    imm_j  = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
    shamt5 = XLEN'(inst[24:20]);
    shamt6 = XLEN'(inst[25:20]);
  end

  always_comb begin
    imm     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b1;
    case (opc)
      OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
        imm     = imm_i;
        fmt     = FMT_I;
        illegal = 1'b0;
      end
      OPC_OPIMM: begin
        illegal = 1'b0;
        if (is_shift(funct3)) begin
          // funct7 (e.g. srai bit 30) is deliberately excluded from the shamt
          imm = IS64 ? shamt6 : shamt5;
          fmt = FMT_ISH;
        end else begin
          imm = imm_i;
          fmt = FMT_I;
        end
      end
      OPC_OPIMM32: begin
        if (IS64) begin
          illegal = 1'b0;
          if (is_shift(funct3)) begin
            imm = shamt5;
            fmt = FMT_ISH;
          end else begin
            imm = imm_i;
            fmt = FMT_I;
          end
        end
      end
      OPC_STORE: begin
        imm     = imm_s;
        fmt     = FMT_S;
        illegal = 1'b0;
      end
      OPC_BRANCH: begin
        imm     = imm_b;
        fmt     = FMT_B;
        illegal = 1'b0;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm     = imm_u;
        fmt     = FMT_U;
        illegal = 1'b0;
      end
      OPC_JAL: begin
        imm     = imm_j;
        fmt     = FMT_J;
        illegal = 1'b0;
      end
      OPC_OP: begin
        fmt     = FMT_R;
        illegal = 1'b0;
      end
      OPC_OP32: begin
        if (IS64) begin
          fmt     = FMT_R;
          illegal = 1'b0;
        end
      end
      default: begin
        imm     = '0;
        fmt     = FMT_NONE;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: decodes on entry, holds results in a main+skid
// buffer so in_ready is a flop and never depends combinationally on out_ready.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input logic         clk,
  input logic         rst,
  imm_gen_pipe_if.slave bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_e;

  buf_state_e      state_q;
  buf_state_e      state_d;
  imm_entry_t      main_q;
  imm_entry_t      skid_q;
  imm_entry_t      in_entry;
  logic            out_valid_q;
  logic            in_ready_q;
  logic            accept;
  logic            drain;
  logic            load_main_in;
  logic            load_main_skid;
  logic            load_skid;
  logic [XLEN-1:0] dec_imm;
  imm_fmt_e        dec_fmt;
  logic            dec_illegal;

  imm_decode #(
    .XLEN (XLEN)
  ) u_decode (
    .inst    (bus.in_inst),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  // Widen the decoded result into the storage format.
  always_comb begin
    in_entry.imm     = IMM_MAX_W'($signed(dec_imm));
    in_entry.fmt     = dec_fmt;
    in_entry.illegal = dec_illegal;
    in_entry.tag     = TAG_MAX_W'(bus.in_tag);
  end

  // An instruction offered in a flush cycle is dropped, never accepted.
  always_comb begin
    accept = bus.in_valid && in_ready_q && !bus.flush;
    drain  = out_valid_q && bus.out_ready;
  end

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (bus.flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            load_main_in = 1'b1;
            state_d      = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            load_skid = 1'b1;
            state_d   = ST_TWO;
          end else if (drain) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only a drain can move the buffer
          if (drain) begin
            load_main_skid = 1'b1;
            state_d        = ST_ONE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_d != ST_EMPTY);
      in_ready_q  <= (state_d != ST_TWO);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= in_entry;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_entry;
      end
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_imm     = XLEN'(main_q.imm);
  assign bus.out_fmt     = main_q.fmt;
  assign bus.out_illegal = main_q.illegal;
  assign bus.out_tag     = TAG_W'(main_q.tag);

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Registered, handshaked immediate generator for the decode stage of the RV32I/RV64I core. It accepts one 32-bit instruction per cycle and decodes every base-ISA immediate format (I, I-shift, S, B, U, J) to a sign-extended XLEN-bit value. It carries a sideband tag and holds results in a 2-entry skid buffer, so fetch→decode back-pressure never forms a combinational ready path. It supersedes the purely combinational immediate generator and sits between the fetch/decode pipeline register and the execute-stage operand muxes.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64 (64 also enables OP-IMM-32 decode and 6-bit shamt)
- TAG_W, 32, width of the opaque sideband passed through with each instruction (typically PC)
- clk  in  1  rising-edge clock; sole clock
- rst  in  1  reset; synchronous and active-high
- flush  in  1  discard all held and incoming instructions this cycle
- in_valid  in  1  instruction offered
- in_ready  out  1  block can accept; registered
- in_inst  in  32  instruction word
- in_tag  in  TAG_W  sideband
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- out_imm  out  XLEN  sign-extended immediate
- out_fmt  out  3  imm_fmt_e format code
- out_illegal  out  1  opcode not in the decoded set
- out_tag  out  TAG_W  sideband of out_imm's instruction

## Operation
- Opcode inst[6:0] selects the format. All results are sign-extended from inst[31] unless stated otherwise.
  - I: 0000011, 0010011 (funct3 ∉ {001,101}), 1100111, 1110011, and 0011011 if XLEN=64 → inst[31:20].
  - I-shift: 0010011/0011011 with funct3 ∈ {001,101} → zero-extended shamt.
    - Shamt is inst[24:20], or inst[25:20] for 0010011 when XLEN=64.
    - The funct7 bits (e.g. srai bit 30) never reach imm.
  - S: 0100011 → {inst[31:25], inst[11:7]}.
  - B: 1100011 → {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}.
  - U: 0110111, 0010111 → {inst[31:12], 12'b0}.
  - J: 1101111 → {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}.
  - R: 0110011, and 0111011 if XLEN=64 → imm 0, fmt R, illegal 0.
  - Any other opcode → imm 0, fmt NONE, illegal 1. This is not an error stall: the entry flows normally.
- Transfer occurs on valid&&ready at each port. Data is decoded on entry, and stored entries hold final imm/fmt/illegal/tag.
- Buffer has two entries: main (drives out_*) and skid.
  - Accept with main empty or draining → write main.
  - Accept with main full and stalled → write skid.
  - When main drains and skid is full, skid moves to main the same edge.
  - in_ready(next) = !skid_valid(next). in_ready drops only when both entries are full.
- flush: both entries are invalidated at the edge, and an in_valid in the flush cycle is dropped. in_ready = 1 the next cycle.
- Outputs are stable while out_valid && !out_ready (no data change, no valid drop).
- Reset values: out_valid 0, out_imm 0, out_fmt NONE, out_illegal 0, out_tag 0, in_ready 1, skid empty.
- Reset dominates flush. rst asserted mid-stream drops all entries. No transfer completes in a reset cycle regardless of valid/ready.

## Timing
- Latency: an instruction accepted at edge N is on out_* from edge N (visible in cycle N+1).
- Throughput: 1/cycle while out_ready=1 and skid unused.
- out_ready low for k cycles with in_valid held:
  - main fills, then skid fills, then in_ready falls.
  - On out_ready rise: one output per cycle, in order, no loss and no duplicate.
  - in_ready returns 1 the cycle after skid empties.
- Simultaneous accept and drain with skid empty: main is replaced in the same edge.
- Decode is combinational only on the input side. out_* and in_ready are register outputs, with no in→out combinational path.

## Structure
- imm_gen_pkg holds:
  - typedef enum logic[2:0] imm_fmt_e {FMT_NONE=0, FMT_R, FMT_I, FMT_ISH, FMT_S, FMT_B, FMT_U, FMT_J}.
  - Opcode localparams: OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_JALR, OPC_SYSTEM, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP, OPC_OP32.
  - Packed struct imm_entry_t {imm, fmt, illegal, tag}.
- Sub-module imm_decode: purely combinational, parameter XLEN, inst → imm/fmt/illegal. It is separately unit-testable.
- imm_gen_pipe instantiates imm_decode and implements the 2-entry buffer.

## Test plan
- XLEN=32, out_ready=1, stream of four instructions:
  - 00052503 (lw) → imm 0, FMT_I.
  - 00050593 (addi) → imm 0, FMT_I.
  - 00112223 (sw) → imm 4, FMT_S.
  - 00500863 (beq) → imm 16, FMT_B.
  - Each appears one cycle after acceptance, in order, with tag intact.
- Sign/format coverage:
  - FFF00093 → FFFFFFFF.
  - 4032D293 (srai 3) → 3, FMT_ISH.
  - 123450B7 → 12345000, FMT_U.
  - FFDFF06F (jal −4) → FFFFFFFC, FMT_J.
  - 00000033 → 0, FMT_R.
  - 0000007F → 0, illegal=1.
- XLEN=64:
  - 800000B7 → FFFFFFFF80000000.
  - 03F51513 (slli 63) → 63.
  - 0015051B (addiw) → 1, FMT_I.
- Back-pressure:
  - Hold out_ready=0 over 3 offered instructions → in_ready=0 after the 2nd is accepted; out_* frozen.
  - Release → both emitted in order, then the 3rd is accepted.
- Flush with both entries full and in_valid=1 → next cycle out_valid=0, in_ready=1, and the flushed/offered instructions never appear.
- rst asserted mid-stream for 1 cycle → all outputs at reset values; first post-reset instruction emits correctly.
